// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: skewed tile feeder; start/len begin a tile, in_valid/in_ready/in_data take beats, out_data/out_valid drive lanes (lane i delayed i+1 cycles), busy/done report status
module systolic_feed_ctrl #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic                   busy,
  output logic                   done
);
  localparam int DW = $clog2(LANES);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [DW-1:0] drain_q, drain_d;
  logic acc;
  assign acc = (state_q == FEED) && in_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = (start && len != '0) ? FEED : IDLE;
      FEED:  state_d = (acc && beat_q + LEN_W'(1) == len_q) ? DRAIN : FEED;
      DRAIN: state_d = (drain_q == DW'(LANES - 1)) ? DONE : DRAIN;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    len_d   = (state_q == IDLE && start) ? len : len_q;
    beat_d  = (state_q == FEED) ? beat_q + LEN_W'(acc) : '0;
    drain_d = (state_q == DRAIN) ? drain_q + DW'(1) : '0;
  end
  always_comb begin
    in_ready = state_q == FEED;
    busy     = state_q != IDLE;
    done     = state_q == DONE;
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] d_q [i+1];
    logic             v_q [i+1];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= acc ? in_data[i*WIDTH +: WIDTH] : '0;
        v_q[0] <= acc;
        for (int k = 1; k <= i; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end
    assign out_data[i*WIDTH +: WIDTH] = d_q[i];
    assign out_valid[i] = v_q[i];
  end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: vector table, corner sequences and random traffic against a cycle-history model
module tb_systolic_feed_ctrl;
  localparam int L = 4, W = 8, LW = 8, MAXC = 4096;
  logic clk, reset, start, in_valid, in_ready, busy, done;
  logic [LW-1:0] len;
  logic [L*W-1:0] in_data, out_data;
  logic [L-1:0] out_valid;
  int checks, errors, cyc, rst_cyc, last_acc, m_need, m_end, dc, fa;
  bit m_act;
  bit hv [MAXC];
  logic [L*W-1:0] hd [MAXC];
  typedef struct {
    logic st; logic [LW-1:0] ln; logic iv; logic [L*W-1:0] d;
    logic rdy, bsy, dn; logic [L-1:0] ov; logic [L*W-1:0] od;
  } vec_t;
  vec_t tbl [10];
  systolic_feed_ctrl #(.LANES(L), .WIDTH(W), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic sample(input bit cm);
    logic [L-1:0] e_ov;
    logic [L*W-1:0] e_od;
    #4;
    if (cm) begin
      e_ov = '0;
      e_od = '0;
      for (int i = 0; i < L; i++) begin
        int k;
        k = cyc - 1 - i;
        if (k >= rst_cyc && hv[k]) begin
          e_ov[i] = 1'b1;
          e_od[i*W +: W] = hd[k][i*W +: W];
        end
      end
      chk("out_valid", out_valid, e_ov);
      chk("out_data", out_data, e_od);
      chk("in_ready", in_ready, m_act && m_need > 0);
      chk("busy", busy, m_act);
      chk("done", done, m_act && m_need == 0 && cyc == m_end);
    end
  endtask
  task automatic adv();
    bit acc;
    @(posedge clk);
    acc = m_act && m_need > 0 && in_valid;
    hv[cyc] = acc;
    hd[cyc] = acc ? in_data : '0;
    if (acc) last_acc = cyc;
    if (!m_act) begin
      if (start && len != 0) begin
        m_act = 1;
        m_need = int'(len);
      end
    end else if (m_need > 0) begin
      if (in_valid) begin
        m_need--;
        if (m_need == 0) m_end = cyc + L + 1;
      end
    end else if (cyc == m_end) m_act = 0;
    cyc++;
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    cyc++;
    rst_cyc = cyc;
    m_act = 0;
    m_need = 0;
    #1;
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
  endtask
  task automatic run_to_done(input string nm, input bit poke, output int d);
    d = -1;
    for (int j = 0; j < 40 && d < 0; j++) begin
      if (poke) begin
        start = m_act && m_need == 0 && cyc == m_end;
        len = 5;
      end
      sample(1);
      if (done === 1'b1) d = cyc;
      adv();
    end
    if (d < 0) chk({nm, "_timeout"}, 0, 1);
  endtask
  initial begin
    checks = 0; errors = 0; rst_cyc = 0; m_act = 0; m_need = 0; m_end = -1; last_acc = 0;
    reset = 1'b1; start = 0; len = 0; in_valid = 0; in_data = 0;
    @(posedge clk);
    cyc = 0;
    #1;
    reset = 1'b0;
    sample(1);
    chk("init_busy", busy, 0);
    chk("init_in_ready", in_ready, 0);
    adv();
    tbl[0] = '{1, 3, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0};
    tbl[1] = '{0, 0, 1, 32'h04030201, 1, 1, 0, 4'b0000, 32'h0};
    tbl[2] = '{0, 0, 1, 32'h08070605, 1, 1, 0, 4'b0001, 32'h00000001};
    tbl[3] = '{0, 0, 1, 32'h0C0B0A09, 1, 1, 0, 4'b0011, 32'h00000205};
    tbl[4] = '{0, 0, 0, 32'h0,        0, 1, 0, 4'b0111, 32'h00030609};
    tbl[5] = '{0, 0, 0, 32'h0,        0, 1, 0, 4'b1110, 32'h04070A00};
    tbl[6] = '{0, 0, 0, 32'h0,        0, 1, 0, 4'b1100, 32'h080B0000};
    tbl[7] = '{0, 0, 0, 32'h0,        0, 1, 0, 4'b1000, 32'h0C000000};
    tbl[8] = '{0, 0, 0, 32'h0,        0, 1, 1, 4'b0000, 32'h0};
    tbl[9] = '{0, 0, 0, 32'h0,        0, 0, 0, 4'b0000, 32'h0};
    for (int r = 0; r < 10; r++) begin
      start = tbl[r].st; len = tbl[r].ln; in_valid = tbl[r].iv; in_data = tbl[r].d;
      sample(1);
      chk($sformatf("tbl%0d_in_ready", r), in_ready, tbl[r].rdy);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].bsy);
      chk($sformatf("tbl%0d_done", r), done, tbl[r].dn);
      chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
      chk($sformatf("tbl%0d_out_data", r), out_data, tbl[r].od);
      adv();
    end
    start = 1; len = 2; in_valid = 0;
    sample(1); adv();
    start = 0; in_valid = 1; in_data = 32'hA4A3A2A1; fa = cyc;
    sample(1); adv();
    in_valid = 0; in_data = 32'hFFFFFFFF;
    sample(1); adv();
    in_valid = 1; in_data = 32'hB4B3B2B1;
    sample(1); adv();
    in_valid = 0;
    run_to_done("bubble", 0, dc);
    chk("bubble_done_lat", dc - fa, L + 3);
    start = 1; len = 0;
    for (int j = 0; j < 3; j++) begin
      sample(1);
      chk("zero_len_busy", busy, 0);
      chk("zero_len_done", done, 0);
      adv();
    end
    start = 1; len = 3;
    sample(1); adv();
    start = 1; len = 5; in_valid = 1; in_data = 32'h11223344;
    sample(1); adv();
    start = 0; in_data = 32'h55667788;
    sample(1); adv();
    in_data = 32'h99AABBCC;
    sample(1); adv();
    in_valid = 0;
    run_to_done("sbusy", 1, dc);
    start = 0;
    chk("sbusy_done_lat", dc - last_acc, L + 1);
    for (int j = 0; j < 3; j++) begin
      sample(1);
      chk("sbusy_idle", busy, 0);
      adv();
    end
    start = 1; len = 4;
    sample(1); adv();
    start = 0; in_valid = 1; in_data = 32'hDEADBEEF;
    sample(1); adv();
    in_data = 32'hCAFEF00D;
    sample(1); adv();
    in_data = 32'h01020304;
    sample(1);
    do_reset();
    for (int j = 0; j < 8; j++) begin
      sample(1);
      chk("rst_no_done", done, 0);
      adv();
    end
    start = 1; len = 1;
    sample(1); adv();
    start = 0; in_valid = 1; in_data = 32'h5A5B5C5D;
    sample(1); adv();
    in_valid = 0;
    run_to_done("rst_new", 0, dc);
    chk("rst_new_done_lat", dc - last_acc, 5);
    for (int j = 0; j < 600; j++) begin
      start = $urandom_range(0, 7) == 0;
      len = LW'($urandom_range(0, 6));
      in_valid = $urandom_range(0, 3) != 0;
      in_data = $urandom;
      sample(1);
      if ($urandom_range(0, 149) == 0) do_reset();
      else adv();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
